mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data normally wins; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err
);

    localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned WaitW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
    localparam logic [WaitW-1:0]   WaitMax   = WaitW'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StBusyIf,
        StBusyDm
    } state_e;

    state_e             state_q, state_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [WaitW-1:0]   wait_inc;
    logic               bus_req_q, bus_req_d;
    logic               bus_we_q, bus_we_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;
    logic               if_done_q, if_done_d;
    logic               dm_done_q, dm_done_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic [31:0]        dm_rdata_q, dm_rdata_d;
    logic               bus_err_q, bus_err_d;

    logic dm_pend;
    logic can_grant;
    logic fetch_first;

    assign dm_pend     = dm_read | dm_write;
    // No grant at all in a done cycle, so the finishing requester can drop its request.
    assign can_grant   = ~if_done_q & ~dm_done_q;
    assign fetch_first = if_req & (~dm_pend | (starve_q == StarveMax));
    assign wait_inc    = wait_q + WaitW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            wait_q      <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        bus_err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (can_grant && fetch_first) begin
                    state_d     = StBusyIf;
                    starve_d    = '0;
                    wait_d      = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                end else if (can_grant && dm_pend) begin
                    state_d     = StBusyDm;
                    wait_d      = '0;
                    bus_req_d   = 1'b1;
                    // Read+write together is performed as a write and flagged.
                    bus_we_d    = dm_write;
                    bus_addr_d  = dm_addr;
                    bus_wdata_d = dm_wdata;
                    bus_err_d   = dm_read & dm_write;
                    if (if_req && (starve_q != StarveMax)) begin
                        starve_d = starve_q + StarveW'(1);
                    end
                end
            end

            StBusyIf, StBusyDm: begin
                if (bus_ack) begin
                    state_d   = StIdle;
                    bus_req_d = 1'b0;
                    wait_d    = '0;
                    if (state_q == StBusyIf) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus_rdata;
                    end else begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = bus_we_q ? '0 : bus_rdata;
                    end
                end else if (wait_inc == WaitMax) begin
                    state_d   = StIdle;
                    bus_req_d = 1'b0;
                    wait_d    = '0;
                    bus_err_d = 1'b1;
                    if (state_q == StBusyIf) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = '0;
                    end
                end else begin
                    wait_d = wait_inc;
                end
            end

            default: begin
                state_d   = StIdle;
                bus_req_d = 1'b0;
            end
        endcase
    end

    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_done   = dm_done_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;
    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = dm_pend & ~dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants and completions are queued as stimulus
// is driven and popped by monitors when the bus grant or done pulse appears.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;

    mem_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT     (15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .dm_read  (dm_read),
        .dm_write (dm_write),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .bus_err  (bus_err)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        bit          chk_wdata;
        logic        err;
    } grant_t;

    typedef struct {
        bit          is_if;
        logic [31:0] rdata;
        logic        err;
        int          busy;
    } done_t;

    grant_t gq[$];
    done_t  dq[$];

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    // Memory responder configuration: ack in BUSY cycle number ack_after (0 = never).
    int          ack_after   = 0;
    logic [31:0] resp_data   = '0;
    logic        resp_ack    = 1'b0;
    logic        ack_in_idle = 1'b0;
    int          busy_cnt    = 0;
    int          last_busy   = 0;

    assign bus_ack   = resp_ack | ack_in_idle;
    assign bus_rdata = resp_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic push_grant(input logic [31:0] a, input logic we, input logic [31:0] wd,
                              input bit chk, input logic err);
        grant_t g;
        g.addr = a; g.we = we; g.wdata = wd; g.chk_wdata = chk; g.err = err;
        gq.push_back(g);
    endtask

    task automatic push_done(input bit is_if, input logic [31:0] rd, input logic err,
                             input int busy);
        done_t d;
        d.is_if = is_if; d.rdata = rd; d.err = err; d.busy = busy;
        dq.push_back(d);
    endtask

    // Waits (bounded) for the requester's done pulse, then drops its request after that cycle.
    task automatic wait_done(input bit is_if, input int budget);
        bit seen;
        seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (is_if ? if_done : dm_done) seen = 1;
        end
        check(is_if ? "if_done_seen" : "dm_done_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        if (is_if) if_req = 1'b0;
        else begin
            dm_read  = 1'b0;
            dm_write = 1'b0;
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_bus_req"},   32'(bus_req),   32'd0);
        check({pfx, "_bus_we"},    32'(bus_we),    32'd0);
        check({pfx, "_bus_addr"},  bus_addr,       32'd0);
        check({pfx, "_bus_wdata"}, bus_wdata,      32'd0);
        check({pfx, "_if_done"},   32'(if_done),   32'd0);
        check({pfx, "_dm_done"},   32'(dm_done),   32'd0);
        check({pfx, "_if_rdata"},  if_rdata,       32'd0);
        check({pfx, "_dm_rdata"},  dm_rdata,       32'd0);
        check({pfx, "_bus_err"},   32'(bus_err),   32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (bus_req) begin
                busy_cnt++;
                resp_ack = (ack_after != 0) && (busy_cnt == ack_after);
            end else begin
                if (busy_cnt != 0) last_busy = busy_cnt;
                busy_cnt = 0;
                resp_ack = 1'b0;
            end
        end
    end

    initial begin : grant_mon
        grant_t cur_g;
        logic   req_prev;
        req_prev = 1'b0;
        cur_g.addr = '0; cur_g.we = 1'b0; cur_g.wdata = '0; cur_g.chk_wdata = 0; cur_g.err = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_req && !req_prev) begin
                if (gq.size() == 0) check("unexpected_grant", 32'd1, 32'd0);
                else begin
                    cur_g = gq.pop_front();
                    check("grant_addr", bus_addr, cur_g.addr);
                    check("grant_we", 32'(bus_we), 32'(cur_g.we));
                    if (cur_g.chk_wdata) check("grant_wdata", bus_wdata, cur_g.wdata);
                    check("grant_err", 32'(bus_err), 32'(cur_g.err));
                end
            end else if (bus_req && req_prev) begin
                check("hold_addr", bus_addr, cur_g.addr);
                check("hold_we", 32'(bus_we), 32'(cur_g.we));
            end
            req_prev = bus_req;
        end
    end

    initial begin : done_mon
        done_t de;
        forever begin
            @(negedge clk);
            if (if_done || dm_done) begin
                done_cnt++;
                if (dq.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else begin
                    de = dq.pop_front();
                    check("done_if", 32'(if_done), 32'(de.is_if));
                    check("done_dm", 32'(dm_done), 32'(!de.is_if));
                    check("done_rdata", de.is_if ? if_rdata : dm_rdata, de.rdata);
                    check("done_err", 32'(bus_err), 32'(de.err));
                    check("done_req_low", 32'(bus_req), 32'd0);
                    if (de.busy != 0) check("busy_cycles", 32'(last_busy), 32'(de.busy));
                    if (de.is_if) check("stall_if_done", 32'(stall_if), 32'd0);
                    else check("stall_mem_done", 32'(stall_mem), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit drop_if;
        int dm_seen;
        int if_seen;
        int saved_done;
        bit reached;

        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_read = 1'b0; dm_write = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        check("reset_stall_if", 32'(stall_if), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single fetch, ack in third BUSY cycle
        ack_after = 3; resp_data = 32'h0050_0093;
        push_grant(32'h100, 1'b0, 32'h0, 0, 1'b0);
        push_done(1, 32'h0050_0093, 1'b0, 3);
        if_addr = 32'h100; if_req = 1'b1;
        @(negedge clk);
        check("stall_if_wait", 32'(stall_if), 32'd1);
        wait_done(1, 40);
        @(negedge clk);
        check("stall_if_after", 32'(stall_if), 32'd0);

        // Store: read data on the bus must not reach dm_rdata
        ack_after = 1; resp_data = 32'h55AA_55AA;
        push_grant(32'h2004, 1'b1, 32'hDEAD_BEEF, 1, 1'b0);
        push_done(0, 32'h0, 1'b0, 1);
        dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF; dm_write = 1'b1;
        wait_done(0, 40);

        // Contention: expected grant order DM,DM,DM,DM,IF,DM
        ack_after = 1; resp_data = 32'h0000_1111;
        for (int i = 0; i < 4; i++) begin
            push_grant(32'h8000, 1'b0, 32'h0, 1, 1'b0);
            push_done(0, 32'h0000_1111, 1'b0, 1);
        end
        push_grant(32'h200, 1'b0, 32'h0, 0, 1'b0);
        push_done(1, 32'h0000_1111, 1'b0, 1);
        push_grant(32'h8000, 1'b0, 32'h0, 1, 1'b0);
        push_done(0, 32'h0000_1111, 1'b0, 1);
        if_addr = 32'h200; dm_addr = 32'h8000; dm_wdata = 32'h0;
        if_req = 1'b1; dm_read = 1'b1;
        dm_seen = 0; if_seen = 0;
        for (int c = 0; c < 200 && dm_seen < 5; c++) begin
            @(negedge clk);
            drop_if = if_done;
            if (if_done) if_seen++;
            if (dm_done) dm_seen++;
            @(posedge clk); #1;
            if (drop_if) if_req = 1'b0;
            if (dm_seen == 5) dm_read = 1'b0;
        end
        if_req = 1'b0; dm_read = 1'b0;
        check("contention_dm_count", 32'(dm_seen), 32'd5);
        check("contention_if_count", 32'(if_seen), 32'd1);

        // Timeout: never acked
        ack_after = 0; resp_data = 32'h7777_7777;
        push_grant(32'h40, 1'b0, 32'h0BAD_0BAD, 1, 1'b0);
        push_done(0, 32'h0, 1'b1, 15);
        dm_addr = 32'h40; dm_wdata = 32'h0BAD_0BAD; dm_read = 1'b1;
        wait_done(0, 60);

        // Illegal read+write: performed as a write, error in grant cycle
        ack_after = 2; resp_data = 32'hAAAA_0000;
        push_grant(32'h3000, 1'b1, 32'h1234_5678, 1, 1'b1);
        push_done(0, 32'h0, 1'b0, 2);
        dm_addr = 32'h3000; dm_wdata = 32'h1234_5678; dm_read = 1'b1; dm_write = 1'b1;
        wait_done(0, 40);

        // Load
        ack_after = 2; resp_data = 32'hCAFE_F00D;
        push_grant(32'h44, 1'b0, 32'h0, 1, 1'b0);
        push_done(0, 32'hCAFE_F00D, 1'b0, 2);
        dm_addr = 32'h44; dm_wdata = 32'h0; dm_read = 1'b1;
        wait_done(0, 40);

        // Reset in the second BUSY cycle of a fetch, then a stray ack
        ack_after = 50; resp_data = 32'hFFFF_FFFF;
        push_grant(32'h400, 1'b0, 32'h0, 0, 1'b0);
        if_addr = 32'h400; if_req = 1'b1;
        saved_done = done_cnt;
        reached = 0;
        for (int c = 0; c < 20 && !reached; c++) begin
            @(posedge clk); #2;
            if (busy_cnt == 2) reached = 1;
        end
        check("reset_busy_reached", 32'(reached), 32'd1);
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk); #2;
        rst = 1'b0; ack_in_idle = 1'b1;
        @(posedge clk); #2;
        ack_in_idle = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_zero("postreset");
        end
        check("no_done_after_reset", 32'(done_cnt), 32'(saved_done));

        check("grant_q_empty", 32'(gq.size()), 32'd0);
        check("done_q_empty", 32'(dq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
